// File: rtl/npc_lsu_pkg.sv
// -----------------------------------------------------------------------------
// npc_lsu_pkg
// Shared constants and types for the NPC load/store master slice.
//   - XLEN / ALIGN_BITS : data width and log2 bytes per memory beat
//   - ST_*              : FSM state encoding used by npc_lsu_master
//   - npc_lsu_size_e    : access size encoding (byte/half/word/dword)
//   - npc_lsu_misaligned: true when the byte offset is not a multiple of size
// -----------------------------------------------------------------------------
package npc_lsu_pkg;

    localparam int XLEN       = 64;
    localparam int ALIGN_BITS = 3;
    localparam int STRB_W     = XLEN / 8;

    // State encoding of the request/response sequencer
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_CAPT  = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2,
        SZ_D = 2'd3
    } npc_lsu_size_e;

    // An access is misaligned when any offset bit below the access size is set
    function automatic logic npc_lsu_misaligned(input logic [ALIGN_BITS-1:0] off,
                                                input logic [1:0]            size);
        logic result;
        result = 1'b0;
        case (size)
            SZ_B:    result = 1'b0;
            SZ_H:    result = off[0];
            SZ_W:    result = |off[1:0];
            default: result = |off;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/npc_lsu_align.sv
// -----------------------------------------------------------------------------
// npc_lsu_align
// Purely combinational lane steering for the load/store master.
//   size_i     : access size (npc_lsu_size_e encoding)
//   off_i      : byte offset of the access inside its memory beat
//   unsigned_i : loads zero-extend when 1, sign-extend when 0
//   wdata_i    : LSB-justified store data
//   rdata_i    : raw beat returned by the memory
//   wmask_o    : byte-lane write mask (lanes past 7 are dropped)
//   wdata_o    : store data shifted into its byte lanes
//   rdata_o    : load data shifted down, truncated and extended
// -----------------------------------------------------------------------------
import npc_lsu_pkg::*;

module npc_lsu_align (
    input  logic [1:0]            size_i,
    input  logic [ALIGN_BITS-1:0] off_i,
    input  logic                  unsigned_i,
    input  logic [XLEN-1:0]       wdata_i,
    input  logic [XLEN-1:0]       rdata_i,
    output logic [STRB_W-1:0]     wmask_o,
    output logic [XLEN-1:0]       wdata_o,
    output logic [XLEN-1:0]       rdata_o
);

    logic [STRB_W-1:0] laneMask;
    logic [XLEN-1:0]   rdataShifted;

    // Store side: the size mask and the data are moved up by the byte offset;
    // the 8-bit mask width silently discards lanes beyond the beat.
    always_comb begin
        laneMask = '0;
        case (size_i)
            SZ_B:    laneMask = 8'h01;
            SZ_H:    laneMask = 8'h03;
            SZ_W:    laneMask = 8'h0F;
            default: laneMask = 8'hFF;
        endcase
        wmask_o = laneMask << off_i;
        wdata_o = wdata_i << {off_i, 3'b000};
    end

    // Load side: bring the addressed byte down to lane 0, then keep only the
    // access size and extend according to unsigned_i.
    always_comb begin
        rdataShifted = rdata_i >> {off_i, 3'b000};
        rdata_o      = '0;
        case (size_i)
            SZ_B: rdata_o = unsigned_i ? {56'd0, rdataShifted[7:0]}
                                       : {{56{rdataShifted[7]}}, rdataShifted[7:0]};
            SZ_H: rdata_o = unsigned_i ? {48'd0, rdataShifted[15:0]}
                                       : {{48{rdataShifted[15]}}, rdataShifted[15:0]};
            SZ_W: rdata_o = unsigned_i ? {32'd0, rdataShifted[31:0]}
                                       : {{32{rdataShifted[31]}}, rdataShifted[31:0]};
            default: rdata_o = rdataShifted;
        endcase
    end

endmodule

// File: rtl/npc_lsu_master.sv
// -----------------------------------------------------------------------------
// npc_lsu_master
// Initiator side of the NPC DPI-C physical-memory port. Accepts one load or
// store at a time, issues a single-cycle memory strobe, captures the memory's
// registered read data and returns an aligned, extended response.
//
// Ports
//   clk_i, rst_ni                 : clock, synchronous active-low reset
//   req_valid_i / req_ready_o     : request handshake (ready only in IDLE)
//   req_wen_i, req_addr_i,
//   req_size_i, req_unsigned_i,
//   req_wdata_i                   : request payload
//   resp_valid_o / resp_ready_i   : response handshake
//   resp_rdata_o, resp_err_o      : load result (0 for stores), error flag
//   mem_valid_o, mem_wen_o,
//   mem_raddr_o, mem_waddr_o,
//   mem_wdata_o, mem_wmask_o      : memory access, driven only in ISSUE
//   mem_rdata_i                   : memory data, valid the cycle after a read
//
// Build option
//   NPC_LSU_MISALIGN_TRAP_EN : misaligned requests skip the memory and return
//                              resp_err=1; otherwise resp_err_o is tied to 0.
// -----------------------------------------------------------------------------
import npc_lsu_pkg::*;

module npc_lsu_master (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_wen_i,
    input  logic [XLEN-1:0]   req_addr_i,
    input  logic [1:0]        req_size_i,
    input  logic              req_unsigned_i,
    input  logic [XLEN-1:0]   req_wdata_i,
    output logic              resp_valid_o,
    input  logic              resp_ready_i,
    output logic [XLEN-1:0]   resp_rdata_o,
    output logic              resp_err_o,
    output logic              mem_valid_o,
    output logic              mem_wen_o,
    output logic [XLEN-1:0]   mem_raddr_o,
    output logic [XLEN-1:0]   mem_waddr_o,
    output logic [XLEN-1:0]   mem_wdata_o,
    output logic [STRB_W-1:0] mem_wmask_o,
    input  logic [XLEN-1:0]   mem_rdata_i
);

    logic [1:0]        state_q, state_d;
    logic              wen_q;
    logic [XLEN-1:0]   addr_q;
    logic [1:0]        size_q;
    logic              unsigned_q;
    logic [XLEN-1:0]   wdata_q;
    logic [XLEN-1:0]   rdata_q, rdata_d;

    logic              accept;
    logic              issue;
    logic [XLEN-1:0]   beatAddr;
    logic [STRB_W-1:0] alignMask;
    logic [XLEN-1:0]   alignWdata;
    logic [XLEN-1:0]   alignRdata;

`ifdef NPC_LSU_MISALIGN_TRAP_EN
    logic              err_q, err_d;
`endif

    assign accept   = (state_q == ST_IDLE) && req_valid_i;
    assign issue    = (state_q == ST_ISSUE);
    assign beatAddr = {addr_q[XLEN-1:ALIGN_BITS], {ALIGN_BITS{1'b0}}};

    npc_lsu_align u_align (
        .size_i     (size_q),
        .off_i      (addr_q[ALIGN_BITS-1:0]),
        .unsigned_i (unsigned_q),
        .wdata_i    (wdata_q),
        .rdata_i    (mem_rdata_i),
        .wmask_o    (alignMask),
        .wdata_o    (alignWdata),
        .rdata_o    (alignRdata)
    );

    // Sequencer: IDLE -> ISSUE -> (CAPT for loads) -> RESP -> IDLE. The
    // response register is cleared on acceptance so stores report zero.
    always_comb begin
        state_d = state_q;
        rdata_d = rdata_q;
`ifdef NPC_LSU_MISALIGN_TRAP_EN
        err_d   = err_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (req_valid_i) begin
                    rdata_d = '0;
                    state_d = ST_ISSUE;
`ifdef NPC_LSU_MISALIGN_TRAP_EN
                    err_d   = 1'b0;
                    if (npc_lsu_misaligned(req_addr_i[ALIGN_BITS-1:0], req_size_i)) begin
                        state_d = ST_RESP;
                        err_d   = 1'b1;
                    end
`endif
                end
            end
            ST_ISSUE: begin
                state_d = wen_q ? ST_RESP : ST_CAPT;
            end
            ST_CAPT: begin
                // mem_rdata_i is only valid in this cycle; the memory clears it next edge
                rdata_d = alignRdata;
                state_d = ST_RESP;
            end
            default: begin
                if (resp_ready_i) begin
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    // State, captured request and response registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            wen_q      <= 1'b0;
            addr_q     <= '0;
            size_q     <= '0;
            unsigned_q <= 1'b0;
            wdata_q    <= '0;
            rdata_q    <= '0;
        end else begin
            state_q <= state_d;
            rdata_q <= rdata_d;
            if (accept) begin
                wen_q      <= req_wen_i;
                addr_q     <= req_addr_i;
                size_q     <= req_size_i;
                unsigned_q <= req_unsigned_i;
                wdata_q    <= req_wdata_i;
            end
        end
    end

`ifdef NPC_LSU_MISALIGN_TRAP_EN
    // Error flag travels with the response and is cleared on each acceptance
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign resp_err_o = err_q;
`else
    assign resp_err_o = 1'b0;
`endif

    // Memory strobe is gated by reset so no access escapes in a reset cycle;
    // all address/data/mask lines are held at zero outside ISSUE.
    always_comb begin
        mem_valid_o = issue && rst_ni;
        mem_wen_o   = issue && rst_ni && wen_q;
        mem_raddr_o = issue ? beatAddr : '0;
        mem_waddr_o = issue ? beatAddr : '0;
        mem_wmask_o = (issue && wen_q) ? alignMask  : '0;
        mem_wdata_o = (issue && wen_q) ? alignWdata : '0;
    end

    assign req_ready_o  = (state_q == ST_IDLE);
    assign resp_valid_o = (state_q == ST_RESP);
    assign resp_rdata_o = rdata_q;

endmodule

// File: doc/npc_lsu_master.md
Name: npc_lsu_master

Overview:
- Initiator side of the NPC DPI-C physical-memory port: takes one load/store request at a time from the execute/LSU stage and drives the memory model's valid/wen/raddr/waddr/wdata/wmask.
- Captures the memory's registered rdata, aligns and extends it, and returns a response.
- Sits between the core pipeline and the DPI-C memory block; at most one transaction in flight.

Parameters:
- XLEN, 64, data/address width; only 64 is supported.
- ALIGN_BITS, 3, log2 of bytes per memory beat; memory addresses are beat-aligned.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted when high with req_valid
- req_wen  in  1  1=store, 0=load
- req_addr  in  64  byte address
- req_size  in  2  0=byte, 1=half, 2=word, 3=dword
- req_unsigned  in  1  loads: zero-extend when 1, sign-extend when 0
- req_wdata  in  64  store data, LSB-justified
- resp_valid  out  1  response present
- resp_ready  in  1  response consumed when high with resp_valid
- resp_rdata  out  64  extended load data; 0 for stores
- resp_err  out  1  misaligned access (only with the optional feature)
- mem_valid  out  1  memory access strobe, one cycle per transaction
- mem_wen  out  1  1=write
- mem_raddr  out  64  beat-aligned read address
- mem_waddr  out  64  beat-aligned write address
- mem_wdata  out  64  lane-shifted write data
- mem_wmask  out  8  byte-lane write mask
- mem_rdata  in  64  memory read data; valid only in the cycle after the mem_valid read cycle

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is synchronous and active-low.
- States: IDLE, ISSUE, CAPT, RESP.
- Reset values: state=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, mem_valid=0, mem_wen=0, all address/data/mask outputs 0.
- IDLE: req_ready=1. When req_valid&&req_ready, register the request and go to ISSUE.
- ISSUE: mem_valid=1 for exactly one cycle.
  - Load: go to CAPT.
  - Store: go to RESP.
- CAPT: sample mem_rdata, which is valid only in this cycle because the memory zeroes it next edge. Shift right by 8*off, where off=addr[2:0]. Truncate to the size, then sign- or zero-extend into resp_rdata. Go to RESP.
- RESP: resp_valid=1, and it holds until resp_ready. On resp_ready go to IDLE. resp_valid and resp_rdata stay stable while stalled.
- Latency: accept at edge k; resp_valid rises at edge k+3 for loads and k+2 for stores. Back-to-back requests cannot overlap; req_ready is 0 outside IDLE.
- Address/mask rules:
  - mem_raddr = mem_waddr = {addr[63:3],3'b000}.
  - Store: mem_wmask = ((1<<(1<<size))-1) << off, truncated to 8 bits; mem_wdata = wdata << (8*off).
  - Load: mem_wmask=0, mem_wdata=0.
- mem_wen is driven only in ISSUE; it is 0 otherwise.
- Misaligned access: (addr & ((1<<size)-1)) != 0. The behaviour depends on the macro below.
- Reset mid-operation: mem_valid is gated by rst_n combinationally, so no memory access occurs in a reset cycle. Any state goes to IDLE at the next edge, and an in-flight response is dropped.
- Simultaneous events: resp_ready in RESP together with req_valid is not accepted that cycle. Acceptance resumes next cycle in IDLE.

Optional Feature:
- Macro: NPC_LSU_MISALIGN_TRAP_EN.
- With the macro defined, a misaligned request goes IDLE→RESP directly without asserting mem_valid. It returns resp_err=1 and resp_rdata=0.
- Without the macro, resp_err is tied to 0. Misaligned offsets are not checked; the mask and shift are computed from off as above, and any bytes beyond lane 7 are silently dropped.

Decomposition:
- Package npc_lsu_pkg: state enum (IDLE/ISSUE/CAPT/RESP), size encodings SZ_B/SZ_H/SZ_W/SZ_D, XLEN and ALIGN_BITS constants.
- Sub-module npc_lsu_align: purely combinational. Computes mem_wmask and the shifted wdata from (size, off, wdata), and the extended load result from (size, off, unsigned, rdata).
- The FSM and registers stay in npc_lsu_master.

Test Plan:
- Store dword: addr=0x80000010, size=3, wdata=0x1122334455667788. Expect ISSUE cycle with mem_waddr=0x80000010, mem_wmask=0xFF, mem_wdata=0x1122334455667788; resp_valid at k+2.
- Store byte: addr=0x80000003, size=0, wdata=0xAB. Expect mem_waddr=0x80000000, mem_wmask=0x08, mem_wdata=0x00000000AB000000.
- Load byte signed: memory returns 0x0000000080000000, addr=0x80000003, size=0, unsigned=0. Expect resp_rdata=0xFFFFFFFFFFFFFF80 at k+3; with unsigned=1, expect 0x80.
- Load word at addr=0x80000004, memory 0xDEADBEEF00000000, unsigned=0. Expect resp_rdata=0xFFFFFFFFDEADBEEF.
- Response stall: hold resp_ready=0 for 5 cycles. Expect resp_valid/resp_rdata stable, req_ready=0, mem_valid=0 throughout; release, then new request accepted next cycle.
- Reset in ISSUE: assert rst_n=0 during ISSUE. Expect mem_valid=0 that cycle, state IDLE next cycle, no resp_valid. With NPC_LSU_MISALIGN_TRAP_EN, a half-word at 0x80000001 returns resp_err=1 at k+1 with no mem_valid.
